// File: rtl/decode_rat_ckpt.sv
// decode_rat_ckpt
//
// Register alias table for the decode stage. Each architectural register
// (1..ARCH_REGS-1) maps to the in-flight ROB entry that will produce it,
// tagged with that producer's fetch ID. A FIFO of branch checkpoints holds
// copies of the table, so a mispredict restores the table to its state at
// the branch instead of wiping it. snoop_hit and bco_valid still flush
// everything.
//
// Ports
//   clk, resetn            rising-edge clock, asynchronous active-low reset
//   snoop_hit, bco_valid   full flush (table and all checkpoints)
//   rd_addr/rd_valid/rd_rob NR combinational read ports on the registered table
//   al_we/al_addr/al_fid/al_rob  allocate a new producer for a register
//   cm_we/cm_addr/cm_fid   commit; clears the mapping only if the FID matches
//   ck_take/ck_id/ck_ready take a checkpoint into slot ck_id (tail)
//   ck_release             free the oldest checkpoint
//   ck_restore/ck_restore_id  restore the table from a live checkpoint
//   ck_count               number of live checkpoints
module decode_rat_ckpt #(
  parameter int ARCH_REGS  = 32,
  parameter int ROB_W      = 4,
  parameter int FID_W      = 8,
  parameter int NR         = 2,
  parameter int CKPT_DEPTH = 4,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int CW        = $clog2(CKPT_DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                snoop_hit,
  input  logic                bco_valid,
  input  logic [NR*AW-1:0]    rd_addr,
  output logic [NR-1:0]       rd_valid,
  output logic [NR*ROB_W-1:0] rd_rob,
  input  logic                al_we,
  input  logic [AW-1:0]       al_addr,
  input  logic [FID_W-1:0]    al_fid,
  input  logic [ROB_W-1:0]    al_rob,
  input  logic                cm_we,
  input  logic [AW-1:0]       cm_addr,
  input  logic [FID_W-1:0]    cm_fid,
  input  logic                ck_take,
  output logic                ck_ready,
  output logic [CW-1:0]       ck_id,
  input  logic                ck_release,
  input  logic                ck_restore,
  input  logic [CW-1:0]       ck_restore_id,
  output logic [CW:0]         ck_count
);

  localparam logic [CW:0] DEPTH_C = (CW+1)'(CKPT_DEPTH);

  // Live table
  logic [ARCH_REGS-1:0] live_v_q, live_v_d;
  logic [FID_W-1:0]     live_fid_q [ARCH_REGS];
  logic [FID_W-1:0]     live_fid_d [ARCH_REGS];
  logic [ROB_W-1:0]     live_rob_q [ARCH_REGS];
  logic [ROB_W-1:0]     live_rob_d [ARCH_REGS];

  // Checkpoint snapshots
  logic [ARCH_REGS-1:0] snap_v_q   [CKPT_DEPTH];
  logic [ARCH_REGS-1:0] snap_v_d   [CKPT_DEPTH];
  logic [FID_W-1:0]     snap_fid_q [CKPT_DEPTH][ARCH_REGS];
  logic [FID_W-1:0]     snap_fid_d [CKPT_DEPTH][ARCH_REGS];
  logic [ROB_W-1:0]     snap_rob_q [CKPT_DEPTH][ARCH_REGS];
  logic [ROB_W-1:0]     snap_rob_d [CKPT_DEPTH][ARCH_REGS];
  logic [CKPT_DEPTH-1:0] snap_live_q, snap_live_d;

  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW:0]   cnt_q, cnt_d;

  // Per-cycle control decisions
  logic          flush;
  logic          rs_ok;
  logic [CW-1:0] rs_dist;
  logic          rel_ok;
  logic          take_ok;
  logic          cm_en;
  logic          al_en;

  assign flush   = snoop_hit | bco_valid;
  // A restore to a slot that is not live is treated as if it never happened.
  assign rs_ok   = ck_restore & snap_live_q[ck_restore_id];
  // Slots older than the restored one survive; modulo arithmetic via CW bits.
  assign rs_dist = ck_restore_id - head_q;
  // On a restore, release only if the restore left something to release.
  assign rel_ok  = ck_release & (rs_ok ? (rs_dist != '0) : (cnt_q != '0));
  // When full, a same-cycle release frees the head slot for this take.
  assign take_ok = ~rs_ok & ck_take & ((cnt_q != DEPTH_C) | rel_ok);
  assign cm_en   = cm_we & (cm_addr != '0);
  assign al_en   = ~rs_ok & al_we & (al_addr != '0);

  always_comb begin
    // Base table: the snapshot on a successful restore, otherwise the live one.
    live_v_d = rs_ok ? snap_v_q[ck_restore_id] : live_v_q;
    for (int r = 0; r < ARCH_REGS; r++) begin
      live_fid_d[r] = rs_ok ? snap_fid_q[ck_restore_id][r] : live_fid_q[r];
      live_rob_d[r] = rs_ok ? snap_rob_q[ck_restore_id][r] : live_rob_q[r];
    end

    // Commit clears only when the entry still names this producer.
    if (cm_en && live_v_d[cm_addr] && (live_fid_d[cm_addr] == cm_fid)) begin
      live_v_d[cm_addr] = 1'b0;
    end

    // Allocate is applied after commit so it wins on the same register.
    if (al_en) begin
      live_v_d[al_addr]   = 1'b1;
      live_fid_d[al_addr] = al_fid;
      live_rob_d[al_addr] = al_rob;
    end

    snap_live_d = snap_live_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    for (int c = 0; c < CKPT_DEPTH; c++) begin
      snap_v_d[c] = snap_v_q[c];
      for (int r = 0; r < ARCH_REGS; r++) begin
        snap_fid_d[c][r] = snap_fid_q[c][r];
        snap_rob_d[c][r] = snap_rob_q[c][r];
      end
      // Commits also scrub live snapshots so a later restore never brings
      // back a mapping to a retired ROB entry.
      if (cm_en && snap_live_q[c] && snap_v_q[c][cm_addr] &&
          (snap_fid_q[c][cm_addr] == cm_fid)) begin
        snap_v_d[c][cm_addr] = 1'b0;
      end
    end

    if (rs_ok) begin
      // Free the restored slot and every younger one.
      for (int c = 0; c < CKPT_DEPTH; c++) begin
        if ((CW'(c) - head_q) >= rs_dist) snap_live_d[c] = 1'b0;
      end
      tail_d = ck_restore_id;
      cnt_d  = {1'b0, rs_dist} - (CW+1)'(rel_ok);
    end else begin
      cnt_d  = cnt_q + (CW+1)'(take_ok) - (CW+1)'(rel_ok);
    end

    // Release before take: when full, both address the same slot.
    if (rel_ok) begin
      snap_live_d[head_q] = 1'b0;
      head_d              = head_q + 1'b1;
    end

    if (take_ok) begin
      snap_v_d[tail_q]    = live_v_d;
      for (int r = 0; r < ARCH_REGS; r++) begin
        snap_fid_d[tail_q][r] = live_fid_d[r];
        snap_rob_d[tail_q][r] = live_rob_d[r];
      end
      snap_live_d[tail_q] = 1'b1;
      tail_d              = tail_q + 1'b1;
    end

    if (flush) begin
      live_v_d    = '0;
      snap_live_d = '0;
      for (int c = 0; c < CKPT_DEPTH; c++) snap_v_d[c] = '0;
      head_d      = '0;
      tail_d      = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_v_q    <= '0;
      snap_live_q <= '0;
      for (int c = 0; c < CKPT_DEPTH; c++) snap_v_q[c] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
    end else begin
      live_v_q    <= live_v_d;
      snap_live_q <= snap_live_d;
      for (int c = 0; c < CKPT_DEPTH; c++) snap_v_q[c] <= snap_v_d[c];
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
    end
  end

  // FID/ROB payloads are qualified by the valids and need no reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ARCH_REGS; r++) begin
      live_fid_q[r] <= live_fid_d[r];
      live_rob_q[r] <= live_rob_d[r];
    end
    for (int c = 0; c < CKPT_DEPTH; c++) begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        snap_fid_q[c][r] <= snap_fid_d[c][r];
        snap_rob_q[c][r] <= snap_rob_d[c][r];
      end
    end
  end

  // Read ports: the ROB index is forced to zero when the mapping is invalid,
  // which also hides the unreset payload after reset.
  always_comb begin
    logic [AW-1:0] ra;
    rd_valid = '0;
    rd_rob   = '0;
    ra       = '0;
    for (int k = 0; k < NR; k++) begin
      ra = rd_addr[k*AW +: AW];
      if ((ra != '0) && live_v_q[ra]) begin
        rd_valid[k]              = 1'b1;
        rd_rob[k*ROB_W +: ROB_W] = live_rob_q[ra];
      end
    end
  end

  assign ck_ready = (cnt_q != DEPTH_C);
  assign ck_id    = tail_q;
  assign ck_count = cnt_q;

endmodule

// File: tb/tb_decode_rat_ckpt.sv
module tb_decode_rat_ckpt;

  localparam int AW    = 5;
  localparam int CW    = 2;
  localparam int ROB_W = 4;
  localparam int FID_W = 8;
  localparam int NR    = 2;

  localparam int K_RD  = 0;
  localparam int K_CNT = 1;
  localparam int K_RDY = 2;
  localparam int K_ID  = 3;

  logic                clk;
  logic                resetn;
  logic                snoop_hit;
  logic                bco_valid;
  logic [NR*AW-1:0]    rd_addr;
  logic [NR-1:0]       rd_valid;
  logic [NR*ROB_W-1:0] rd_rob;
  logic                al_we;
  logic [AW-1:0]       al_addr;
  logic [FID_W-1:0]    al_fid;
  logic [ROB_W-1:0]    al_rob;
  logic                cm_we;
  logic [AW-1:0]       cm_addr;
  logic [FID_W-1:0]    cm_fid;
  logic                ck_take;
  logic                ck_ready;
  logic [CW-1:0]       ck_id;
  logic                ck_release;
  logic                ck_restore;
  logic [CW-1:0]       ck_restore_id;
  logic [CW:0]         ck_count;

  decode_rat_ckpt #(
    .ARCH_REGS(32), .ROB_W(ROB_W), .FID_W(FID_W), .NR(NR), .CKPT_DEPTH(4)
  ) dut (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_rob(rd_rob),
    .al_we(al_we), .al_addr(al_addr), .al_fid(al_fid), .al_rob(al_rob),
    .cm_we(cm_we), .cm_addr(cm_addr), .cm_fid(cm_fid),
    .ck_take(ck_take), .ck_ready(ck_ready), .ck_id(ck_id),
    .ck_release(ck_release), .ck_restore(ck_restore),
    .ck_restore_id(ck_restore_id), .ck_count(ck_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Scoreboard: expectations are queued with the stimulus, popped on output.
  string       tag_q[$];
  int          kind_q[$];
  logic [31:0] exp_q[$];

  task automatic push(input string t, input int k, input logic [31:0] e);
    tag_q.push_back(t);
    kind_q.push_back(k);
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_RD:    return {22'b0, rd_valid, rd_rob};
      K_CNT:   return {29'b0, ck_count};
      K_RDY:   return {31'b0, ck_ready};
      default: return {30'b0, ck_id};
    endcase
  endfunction

  task automatic drain();
    string       t;
    int          k;
    logic [31:0] e;
    logic [31:0] o;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      o = observe(k);
      ncmp++;
      assert (o === e) else begin
        nerr++;
        $error("FAIL %s observed=%0h expected=%0h", t, o, e);
      end
    end
  endtask

  task automatic idle();
    snoop_hit     = 1'b0;
    bco_valid     = 1'b0;
    al_we         = 1'b0;
    al_addr       = '0;
    al_fid        = '0;
    al_rob        = '0;
    cm_we         = 1'b0;
    cm_addr       = '0;
    cm_fid        = '0;
    ck_take       = 1'b0;
    ck_release    = 1'b0;
    ck_restore    = 1'b0;
    ck_restore_id = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic alloc(input logic [AW-1:0] a, input logic [FID_W-1:0] f,
                       input logic [ROB_W-1:0] r);
    al_we = 1'b1; al_addr = a; al_fid = f; al_rob = r;
  endtask

  task automatic commit(input logic [AW-1:0] a, input logic [FID_W-1:0] f);
    cm_we = 1'b1; cm_addr = a; cm_fid = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle();
    rd(5'd0, 5'd5);
    push("reset_rd",    K_RD,  32'h0);
    push("reset_ready", K_RDY, 32'h1);
    push("reset_count", K_CNT, 32'h0);
    push("reset_id",    K_ID,  32'h0);
    #2;
    drain();
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Allocate r5; the table must not bypass the allocate combinationally.
    idle(); alloc(5'd5, 8'h11, 4'd3); rd(5'd5, 5'd0);
    push("no_bypass", K_RD, 32'h0);
    #1; drain();
    push("alloc_r5", K_RD, 32'h103);
    tick(); drain();

    idle(); commit(5'd5, 8'h12); rd(5'd5, 5'd0);
    push("commit_fid_miss", K_RD, 32'h103);
    tick(); drain();

    idle(); commit(5'd5, 8'h11);
    push("commit_fid_hit", K_RD, 32'h0);
    tick(); drain();

    // Checkpoint captures the same-cycle allocate of r7.
    idle(); alloc(5'd7, 8'h01, 4'd2); ck_take = 1'b1; rd(5'd7, 5'd0);
    push("take_id_before", K_ID, 32'h0);
    #1; drain();
    push("take_rd",    K_RD,  32'h102);
    push("take_count", K_CNT, 32'h1);
    push("take_id",    K_ID,  32'h1);
    tick(); drain();

    idle(); alloc(5'd7, 8'h02, 4'd9);
    push("realloc_r7", K_RD, 32'h109);
    tick(); drain();

    idle(); ck_restore = 1'b1; ck_restore_id = 2'd0;
    push("restore_rd",    K_RD,  32'h102);
    push("restore_count", K_CNT, 32'h0);
    push("restore_id",    K_ID,  32'h0);
    tick(); drain();

    // Fill the checkpoint FIFO.
    idle(); ck_take = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    push("full_count", K_CNT, 32'h4);
    push("full_ready", K_RDY, 32'h0);
    drain();

    idle(); ck_take = 1'b1;
    push("drop_count", K_CNT, 32'h4);
    push("drop_id",    K_ID,  32'h0);
    tick(); drain();

    idle(); ck_take = 1'b1; ck_release = 1'b1;
    push("tr_count", K_CNT, 32'h4);
    push("tr_id",    K_ID,  32'h1);
    push("tr_ready", K_RDY, 32'h0);
    tick(); drain();

    idle(); snoop_hit = 1'b1; rd(5'd7, 5'd0);
    push("snoop_rd",    K_RD,  32'h0);
    push("snoop_count", K_CNT, 32'h0);
    push("snoop_id",    K_ID,  32'h0);
    push("snoop_ready", K_RDY, 32'h1);
    tick(); drain();

    // Commit scrubs the checkpoint copy of r3.
    idle(); alloc(5'd3, 8'h20, 4'd5); ck_take = 1'b1; rd(5'd3, 5'd0);
    push("r3_alloc", K_RD, 32'h105);
    tick(); drain();

    idle(); commit(5'd3, 8'h20);
    push("r3_commit", K_RD, 32'h0);
    tick(); drain();

    idle(); ck_restore = 1'b1; ck_restore_id = 2'd0; alloc(5'd3, 8'h21, 4'd6);
    push("restore_scrubbed", K_RD,  32'h0);
    push("restore_scrub_cnt", K_CNT, 32'h0);
    tick(); drain();

    // Restore ignores a same-cycle allocate.
    idle(); alloc(5'd3, 8'h30, 4'd7); ck_take = 1'b1; rd(5'd3, 5'd4);
    push("r3_take", K_RD, 32'h107);
    tick(); drain();

    idle(); ck_restore = 1'b1; ck_restore_id = 2'd0; alloc(5'd4, 8'h01, 4'd8);
    push("restore_no_alloc", K_RD,  32'h107);
    push("restore_cnt2",     K_CNT, 32'h0);
    tick(); drain();

    // Restore to a non-live slot: normal processing.
    idle(); ck_restore = 1'b1; ck_restore_id = 2'd2; alloc(5'd4, 8'h01, 4'd8);
    push("restore_dead", K_RD,  32'h387);
    push("restore_dead_cnt", K_CNT, 32'h0);
    tick(); drain();

    // Commit applied on top of the restored snapshot.
    idle(); ck_take = 1'b1;
    push("take3_count", K_CNT, 32'h1);
    tick(); drain();

    idle(); ck_restore = 1'b1; ck_restore_id = 2'd0; commit(5'd3, 8'h30);
    push("restore_commit", K_RD,  32'h280);
    push("restore_commit_cnt", K_CNT, 32'h0);
    tick(); drain();

    // Three live checkpoints, then a full flush from bco_valid.
    idle(); ck_take = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    push("three_count", K_CNT, 32'h3);
    push("three_id",    K_ID,  32'h3);
    drain();

    idle(); alloc(5'd1, 8'h05, 4'hA); rd(5'd1, 5'd0);
    push("r1_alloc", K_RD, 32'h10A);
    tick(); drain();

    idle(); bco_valid = 1'b1; ck_take = 1'b1; alloc(5'd2, 8'h06, 4'd1); rd(5'd1, 5'd2);
    push("bco_rd",    K_RD,  32'h0);
    push("bco_count", K_CNT, 32'h0);
    push("bco_id",    K_ID,  32'h0);
    push("bco_ready", K_RDY, 32'h1);
    tick(); drain();

    idle(); ck_release = 1'b1;
    push("rel_empty_cnt", K_CNT, 32'h0);
    push("rel_empty_id",  K_ID,  32'h0);
    tick(); drain();

    // Asynchronous reset mid-stream, between clock edges.
    idle(); alloc(5'd1, 8'h01, 4'd1); ck_take = 1'b1; rd(5'd1, 5'd0);
    push("pre_reset_rd",  K_RD,  32'h101);
    push("pre_reset_cnt", K_CNT, 32'h1);
    tick(); drain();
    idle();
    #2;
    resetn = 1'b0;
    #1;
    push("async_rd",  K_RD,  32'h0);
    push("async_cnt", K_CNT, 32'h0);
    push("async_id",  K_ID,  32'h0);
    drain();
    tick();
    resetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
